// File: rtl/sensor_poll_sequencer.sv
// Periodic three-byte register read over the SPI byte engine.
// Ports: clk, reset (async low), enable; byte_start/byte_tx/byte_done/byte_rx
// engine handshake; cs_hold; sample/sample_valid/above_thr; timeout_err.
module sensor_poll_sequencer #(
  parameter int unsigned POLL_CYCLES = 1000,
  parameter logic [7:0]  REG_ADDR    = 8'h33,
  parameter int unsigned TIMEOUT     = 255,
  parameter logic [15:0] THRESH      = 16'h0800
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        byte_start,
  output logic [7:0]  byte_tx,
  input  logic        byte_done,
  input  logic [7:0]  byte_rx,
  output logic        cs_hold,
  output logic [15:0] sample,
  output logic        sample_valid,
  output logic        above_thr,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    IDLE, WAIT, ADDR, DATA_H, DATA_L, DONE
  } state_t;

  localparam logic [19:0] POLL_LOAD = 20'(POLL_CYCLES - 1);
  localparam logic [7:0]  WD_LAST   = 8'(TIMEOUT - 1);
  localparam logic [7:0]  TX_ADDR   = REG_ADDR | 8'h80;

  state_t      state, state_nx;
  logic        issued, issued_nx;
  logic [7:0]  wd, wd_nx;
  logic [19:0] cnt, cnt_nx;
  logic [7:0]  hi, hi_nx;
  logic [7:0]  lo, lo_nx;

  logic        byte_start_nx;
  logic [7:0]  byte_tx_nx;
  logic        cs_hold_nx;
  logic [15:0] sample_nx;
  logic        sample_valid_nx;
  logic        above_thr_nx;
  logic        timeout_err_nx;

  logic        in_byte;
  logic        got;
  logic        tmo;

  // issued: the byte_start for this state has gone out, so
  // byte_done and the watchdog only count after that.
  assign in_byte = (state == ADDR) || (state == DATA_H) ||
                   (state == DATA_L);
  assign got = in_byte && issued && byte_done;
  assign tmo = in_byte && issued && !byte_done &&
               (wd == WD_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (enable) state_nx = ADDR;
      WAIT:    if (cnt == '0) state_nx = enable ? ADDR : IDLE;
      ADDR:    if (got) state_nx = DATA_H;
               else if (tmo) state_nx = WAIT;
      DATA_H:  if (got) state_nx = DATA_L;
               else if (tmo) state_nx = WAIT;
      DATA_L:  if (got) state_nx = DONE;
               else if (tmo) state_nx = WAIT;
      DONE:    state_nx = WAIT;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    byte_start_nx   = in_byte && !issued;
    issued_nx       = in_byte && (state_nx == state);
    byte_tx_nx      = byte_tx;
    if (byte_start_nx)
      byte_tx_nx = (state == ADDR) ? TX_ADDR : 8'h00;
    cs_hold_nx      = in_byte && (state_nx != WAIT) &&
                      (cs_hold || byte_start_nx);
    wd_nx           = (!in_byte || byte_start_nx) ?
                      8'h00 : wd + 8'd1;
    hi_nx           = (state == DATA_H && got) ? byte_rx : hi;
    lo_nx           = (state == DATA_L && got) ? byte_rx : lo;
    sample_nx       = sample;
    sample_valid_nx = 1'b0;
    above_thr_nx    = above_thr;
    timeout_err_nx  = timeout_err;
    cnt_nx          = cnt;
    unique case (1'b1)
      (state == DONE): begin
        sample_nx       = {hi, lo};
        sample_valid_nx = 1'b1;
        above_thr_nx    = ({hi, lo} > THRESH);
        timeout_err_nx  = 1'b0;
        cnt_nx          = POLL_LOAD;
      end
      tmo: begin
        timeout_err_nx = 1'b1;
        cnt_nx         = POLL_LOAD;
      end
      (state == WAIT): begin
        if (cnt != '0) cnt_nx = cnt - 20'd1;
      end
      (state == IDLE): cnt_nx = '0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issued       <= 1'b0;
      wd           <= '0;
      cnt          <= '0;
      hi           <= '0;
      lo           <= '0;
      byte_start   <= 1'b0;
      byte_tx      <= '0;
      cs_hold      <= 1'b0;
      sample       <= '0;
      sample_valid <= 1'b0;
      above_thr    <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      issued       <= issued_nx;
      wd           <= wd_nx;
      cnt          <= cnt_nx;
      hi           <= hi_nx;
      lo           <= lo_nx;
      byte_start   <= byte_start_nx;
      byte_tx      <= byte_tx_nx;
      cs_hold      <= cs_hold_nx;
      sample       <= sample_nx;
      sample_valid <= sample_valid_nx;
      above_thr    <= above_thr_nx;
      timeout_err  <= timeout_err_nx;
    end
  end

endmodule
